wb_commit_buffer: RTL and testbench
===================================

WB_COMMIT_BUFFER -- requirements
Module: wb_commit_buffer

Interface
REQ-001 Parameter XLEN, default 32, data/PC/mcause width.
REQ-002 Parameter DEPTH, default 4, entry count; power of two, >=2.
REQ-003 Parameter REG_AW, default 5, register address width.
REQ-004 Parameter CSR_AW, default 12, CSR address width.
REQ-005 Ports, one clock; reset asynchronous, active-high:
- clk  in  1  clock
- rst  in  1  async active-high reset
- flush  in  1  discard all buffered entries
- in_valid  in  1  retire entry offered
- in_ready  out  1  entry accepted when in_valid&in_ready
- in_rd_addr  in  REG_AW  destination register
- in_rd_wdata  in  XLEN  register write data
- in_csr_we  in  1  entry writes a CSR
- in_csr_addr  in  CSR_AW  CSR address
- in_csr_wdata  in  XLEN  CSR write data
- in_trap  in  1  entry is a trap
- in_trap_mcause  in  XLEN  trap cause
- in_trap_pc  in  XLEN  trapping PC
- rd_we  out  1  register file write strobe
- rd_addr  out  REG_AW  register write address
- rd_wdata  out  XLEN  register write data
- csr_we  out  1  CSR write request
- csr_ready  in  1  CSR file accepts write
- csr_addr  out  CSR_AW  CSR address
- csr_wdata  out  XLEN  CSR data
- trap_valid  out  1  one-cycle trap commit pulse
- trap_mcause  out  XLEN  committed trap cause
- trap_pc  out  XLEN  committed trap PC
- instret  out  64  retired non-trap instruction count
- count  out  log2(DEPTH)+1  occupied entries

Function
REQ-006 Storage SHALL be a circular FIFO of DEPTH entries, read/write pointers wrapping modulo DEPTH.
REQ-007 A push SHALL write at the write pointer on the rising edge when in_valid&in_ready; the entry reaches the head no earlier than the next cycle (minimum latency 1 cycle in to commit).
REQ-008 head_valid SHALL be count!=0; all outputs SHALL be combinational from the head entry.
REQ-009 Commit SHALL occur in a cycle where head_valid and (head.trap or !head.csr_we or csr_ready); commit pops the head at the edge.
REQ-010 rd_we SHALL equal commit & !head.trap & head.rd_addr!=0; writes to x0 suppressed but still commit.
REQ-011 csr_we SHALL equal head_valid & head.csr_we & !head.trap, held with stable addr/data until csr_ready; no commit while it waits.
REQ-012 trap_valid SHALL equal commit & head.trap; trap entries never assert rd_we or csr_we.
REQ-013 On trap commit all remaining entries SHALL be discarded (count->0) and in_ready SHALL be 0 in that cycle.
REQ-014 in_ready SHALL be !flush & !(trap commit) & (count<DEPTH or commit); push and pop in the same cycle when full is legal, count unchanged.
REQ-015 count SHALL update by +1 push-only, -1 pop-only, 0 both, never exceeding DEPTH or below 0.
REQ-016 instret SHALL increment by 1 on every non-trap commit, wrapping at 2^64.
REQ-017 flush SHALL clear count and pointers at the edge, suppress push and commit that cycle, and force rd_we, csr_we, trap_valid to 0 combinationally; instret unchanged.
REQ-018 Simultaneous flush and trap commit: flush wins, trap_valid 0.
REQ-019 Idle outputs (count=0): rd_we, csr_we, trap_valid 0; data outputs don't-care.

Reset
REQ-020 rst SHALL asynchronously clear pointers, count and instret to 0; in_ready 1 and all strobes 0 while rst is high.
REQ-021 Entry storage SHALL NOT require reset.
REQ-022 Reset mid-operation SHALL discard all entries, including a pending CSR write, with no strobe asserted after rst rises.

Verification
REQ-023 Single entry rd=5, wdata=0xDEADBEEF pushed at cycle N -> rd_we=1, rd_addr=5, rd_wdata=0xDEADBEEF at N+1; instret=1.
REQ-024 Entry rd=0 -> rd_we never asserted, instret increments by 1.
REQ-025 CSR entry addr 0x300 data 0x8, csr_ready low 3 cycles -> csr_we held 3+ cycles, commit on cycle csr_ready=1, following entry waits.
REQ-026 Fill DEPTH=4, then push while committing -> in_ready=1, count stays 4; with no commit, in_ready=0 at count 4.
REQ-027 Entries A, trap(mcause=0x2, pc=0x100), B, C -> A commits, trap_valid pulse with 0x2/0x100, B and C never write, count=0, instret=1.
REQ-028 Assert rst while CSR write stalled and count=3 -> strobes 0 immediately, count=0, instret=0.

Source files
------------

// File: rtl/wb_commit_if.sv
// rtl/wb_commit_if.sv - retire-side and commit-side signal bundle for wb_commit_buffer
interface wb_commit_if #(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 4,
    parameter int REG_AW = 5,
    parameter int CSR_AW = 12
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [REG_AW-1:0] in_rd_addr;
    logic [XLEN-1:0]   in_rd_wdata;
    logic              in_csr_we;
    logic [CSR_AW-1:0] in_csr_addr;
    logic [XLEN-1:0]   in_csr_wdata;
    logic              in_trap;
    logic [XLEN-1:0]   in_trap_mcause;
    logic [XLEN-1:0]   in_trap_pc;
    logic              rd_we;
    logic [REG_AW-1:0] rd_addr;
    logic [XLEN-1:0]   rd_wdata;
    logic              csr_we;
    logic              csr_ready;
    logic [CSR_AW-1:0] csr_addr;
    logic [XLEN-1:0]   csr_wdata;
    logic              trap_valid;
    logic [XLEN-1:0]   trap_mcause;
    logic [XLEN-1:0]   trap_pc;
    logic [63:0]       instret;
    logic [CW-1:0]     count;

    modport slave (
        input  flush, in_valid, in_rd_addr, in_rd_wdata, in_csr_we, in_csr_addr,
               in_csr_wdata, in_trap, in_trap_mcause, in_trap_pc, csr_ready,
        output in_ready, rd_we, rd_addr, rd_wdata, csr_we, csr_addr, csr_wdata,
               trap_valid, trap_mcause, trap_pc, instret, count
    );

    modport master (
        output flush, in_valid, in_rd_addr, in_rd_wdata, in_csr_we, in_csr_addr,
               in_csr_wdata, in_trap, in_trap_mcause, in_trap_pc, csr_ready,
        input  in_ready, rd_we, rd_addr, rd_wdata, csr_we, csr_addr, csr_wdata,
               trap_valid, trap_mcause, trap_pc, instret, count
    );
endinterface

// File: rtl/wb_commit_buffer.sv
// rtl/wb_commit_buffer.sv - in-order retire FIFO committing register, CSR and trap effects
module wb_commit_buffer #(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 4,
    parameter int REG_AW = 5,
    parameter int CSR_AW = 12
) (
    input  logic       clk,
    input  logic       rst,
    wb_commit_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [REG_AW-1:0] rd_addr;
        logic [XLEN-1:0]   rd_wdata;
        logic              csr_we;
        logic [CSR_AW-1:0] csr_addr;
        logic [XLEN-1:0]   csr_wdata;
        logic              trap;
        logic [XLEN-1:0]   mcause;
        logic [XLEN-1:0]   pc;
    } entry_t;

    entry_t        mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [63:0]   instret_q, instret_d;

    entry_t head;
    entry_t in_entry;
    logic   head_valid;
    logic   commit;
    logic   trap_commit;
    logic   push;
    logic   in_ready;

    always_comb begin
        in_entry.rd_addr   = bus.in_rd_addr;
        in_entry.rd_wdata  = bus.in_rd_wdata;
        in_entry.csr_we    = bus.in_csr_we;
        in_entry.csr_addr  = bus.in_csr_addr;
        in_entry.csr_wdata = bus.in_csr_wdata;
        in_entry.trap      = bus.in_trap;
        in_entry.mcause    = bus.in_trap_mcause;
        in_entry.pc        = bus.in_trap_pc;
    end

    // A stalled CSR write blocks its own commit; flush overrides everything, including traps.
    always_comb begin
        head        = mem_q[rd_ptr_q];
        head_valid  = (count_q != '0);
        commit      = head_valid && !bus.flush &&
                      (head.trap || !head.csr_we || bus.csr_ready);
        trap_commit = commit && head.trap;
        in_ready    = rst || (!bus.flush && !trap_commit && ((count_q < FULL) || commit));
        push        = bus.in_valid && in_ready && !rst;
    end

    always_comb begin
        bus.in_ready    = in_ready;
        bus.rd_we       = commit && !head.trap && (head.rd_addr != '0);
        bus.rd_addr     = head.rd_addr;
        bus.rd_wdata    = head.rd_wdata;
        bus.csr_we      = head_valid && head.csr_we && !head.trap && !bus.flush;
        bus.csr_addr    = head.csr_addr;
        bus.csr_wdata   = head.csr_wdata;
        bus.trap_valid  = trap_commit;
        bus.trap_mcause = head.mcause;
        bus.trap_pc     = head.pc;
        bus.instret     = instret_q;
        bus.count       = count_q;
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        instret_d = instret_q;
        if (commit && !head.trap) begin
            instret_d = instret_q + 64'd1;
        end
        if (bus.flush || trap_commit) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (commit) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push, commit})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            instret_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            instret_q <= instret_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_entry;
        end
    end
endmodule

// File: tb/tb_wb_commit_buffer.sv
// tb/tb_wb_commit_buffer.sv - directed and randomized checks of wb_commit_buffer against a queue model
module tb_wb_commit_buffer;
    localparam int XLEN = 32, DEPTH = 4, REG_AW = 5, CSR_AW = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    wb_commit_if #(.XLEN(XLEN), .DEPTH(DEPTH), .REG_AW(REG_AW), .CSR_AW(CSR_AW)) bus ();

    wb_commit_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .REG_AW(REG_AW), .CSR_AW(CSR_AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] wd;
        logic        cwe;
        logic [11:0] ca;
        logic [31:0] cd;
        logic        trap;
        logic [31:0] mc;
        logic [31:0] pc;
    } ent_t;

    ent_t mdl_q[$];

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_in(input logic v, input logic [4:0] rd, input logic [31:0] wd,
                          input logic cwe, input logic [11:0] ca, input logic [31:0] cd,
                          input logic trap, input logic [31:0] mc, input logic [31:0] pc);
        bus.in_valid       = v;
        bus.in_rd_addr     = rd;
        bus.in_rd_wdata    = wd;
        bus.in_csr_we      = cwe;
        bus.in_csr_addr    = ca;
        bus.in_csr_wdata   = cd;
        bus.in_trap        = trap;
        bus.in_trap_mcause = mc;
        bus.in_trap_pc     = pc;
    endtask

    task automatic idle_in();
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 12'd0, 32'd0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.flush = 1'b0;
        bus.csr_ready = 1'b1;
        idle_in();
        #1;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b want 1", bus.in_ready); end
        n_checks++; if (bus.rd_we !== 1'b0) begin n_fail++; $display("FAIL reset_rd_we: got %0b want 0", bus.rd_we); end
        n_checks++; if (bus.csr_we !== 1'b0) begin n_fail++; $display("FAIL reset_csr_we: got %0b want 0", bus.csr_we); end
        n_checks++; if (bus.trap_valid !== 1'b0) begin n_fail++; $display("FAIL reset_trap_valid: got %0b want 0", bus.trap_valid); end
        n_checks++; if (bus.count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bus.count); end
        n_checks++; if (bus.instret !== 64'd0) begin n_fail++; $display("FAIL reset_instret: got %0d want 0", bus.instret); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        set_in(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 12'd0, 32'd0, 1'b0, 32'd0, 32'd0);
        #1;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL single_in_ready: got %0b want 1", bus.in_ready); end
        n_checks++; if (bus.rd_we !== 1'b0) begin n_fail++; $display("FAIL single_early_rd_we: got %0b want 0", bus.rd_we); end
        tick();
        idle_in();
        #1;
        n_checks++; if (bus.rd_we !== 1'b1) begin n_fail++; $display("FAIL single_rd_we: got %0b want 1", bus.rd_we); end
        n_checks++; if (bus.rd_addr !== 5'd5) begin n_fail++; $display("FAIL single_rd_addr: got %0d want 5", bus.rd_addr); end
        n_checks++; if (bus.rd_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_rd_wdata: got %0h want deadbeef", bus.rd_wdata); end
        tick();
        #1;
        n_checks++; if (bus.instret !== 64'd1) begin n_fail++; $display("FAIL single_instret: got %0d want 1", bus.instret); end
        n_checks++; if (bus.count !== 3'd0) begin n_fail++; $display("FAIL single_count: got %0d want 0", bus.count); end
    endtask

    task automatic test_x0();
        set_in(1'b1, 5'd0, 32'h1234, 1'b0, 12'd0, 32'd0, 1'b0, 32'd0, 32'd0);
        tick();
        idle_in();
        #1;
        n_checks++; if (bus.rd_we !== 1'b0) begin n_fail++; $display("FAIL x0_rd_we: got %0b want 0", bus.rd_we); end
        n_checks++; if (bus.count !== 3'd1) begin n_fail++; $display("FAIL x0_count: got %0d want 1", bus.count); end
        tick();
        #1;
        n_checks++; if (bus.count !== 3'd0) begin n_fail++; $display("FAIL x0_drain: got %0d want 0", bus.count); end
        n_checks++; if (bus.instret !== 64'd2) begin n_fail++; $display("FAIL x0_instret: got %0d want 2", bus.instret); end
    endtask

    task automatic test_csr_stall();
        bus.csr_ready = 1'b0;
        set_in(1'b1, 5'd0, 32'd0, 1'b1, 12'h300, 32'h8, 1'b0, 32'd0, 32'd0);
        tick();
        set_in(1'b1, 5'd3, 32'hA5, 1'b0, 12'd0, 32'd0, 1'b0, 32'd0, 32'd0);
        tick();
        idle_in();
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (bus.csr_we !== 1'b1) begin n_fail++; $display("FAIL csr_hold_we[%0d]: got %0b want 1", i, bus.csr_we); end
            n_checks++; if (bus.csr_addr !== 12'h300 || bus.csr_wdata !== 32'h8) begin n_fail++; $display("FAIL csr_hold_data[%0d]: got %0h/%0h want 300/8", i, bus.csr_addr, bus.csr_wdata); end
            n_checks++; if (bus.count !== 3'd2 || bus.rd_we !== 1'b0) begin n_fail++; $display("FAIL csr_hold_wait[%0d]: got count %0d rd_we %0b want 2/0", i, bus.count, bus.rd_we); end
            tick();
        end
        bus.csr_ready = 1'b1;
        #1;
        n_checks++; if (bus.csr_we !== 1'b1) begin n_fail++; $display("FAIL csr_release_we: got %0b want 1", bus.csr_we); end
        tick();
        #1;
        n_checks++; if (bus.count !== 3'd1 || bus.rd_we !== 1'b1 || bus.rd_addr !== 5'd3) begin n_fail++; $display("FAIL csr_follow: got count %0d rd_we %0b rd %0d want 1/1/3", bus.count, bus.rd_we, bus.rd_addr); end
        tick();
        #1;
        n_checks++; if (bus.instret !== 64'd4) begin n_fail++; $display("FAIL csr_instret: got %0d want 4", bus.instret); end
    endtask

    task automatic test_full();
        bus.csr_ready = 1'b0;
        set_in(1'b1, 5'd0, 32'd0, 1'b1, 12'h305, 32'h1, 1'b0, 32'd0, 32'd0);
        tick();
        for (int i = 1; i < 4; i++) begin
            set_in(1'b1, 5'(i), 32'(i), 1'b0, 12'd0, 32'd0, 1'b0, 32'd0, 32'd0);
            tick();
        end
        set_in(1'b1, 5'd4, 32'd4, 1'b0, 12'd0, 32'd0, 1'b0, 32'd0, 32'd0);
        #1;
        n_checks++; if (bus.count !== 3'd4 || bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL full_block: got count %0d in_ready %0b want 4/0", bus.count, bus.in_ready); end
        tick();
        #1;
        n_checks++; if (bus.count !== 3'd4) begin n_fail++; $display("FAIL full_hold: got %0d want 4", bus.count); end
        bus.csr_ready = 1'b1;
        #1;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL full_passthru_ready: got %0b want 1", bus.in_ready); end
        tick();
        idle_in();
        #1;
        n_checks++; if (bus.count !== 3'd4) begin n_fail++; $display("FAIL full_push_pop_count: got %0d want 4", bus.count); end
        repeat (4) tick();
        #1;
        n_checks++; if (bus.count !== 3'd0 || bus.instret !== 64'd9) begin n_fail++; $display("FAIL full_drain: got count %0d instret %0d want 0/9", bus.count, bus.instret); end
    endtask

    task automatic test_trap();
        bus.csr_ready = 1'b0;
        set_in(1'b1, 5'd0, 32'd0, 1'b1, 12'h340, 32'h55, 1'b0, 32'd0, 32'd0);
        tick();
        set_in(1'b1, 5'd0, 32'd0, 1'b0, 12'd0, 32'd0, 1'b1, 32'h2, 32'h100);
        tick();
        set_in(1'b1, 5'd2, 32'hB, 1'b0, 12'd0, 32'd0, 1'b0, 32'd0, 32'd0);
        tick();
        set_in(1'b1, 5'd3, 32'hC, 1'b0, 12'd0, 32'd0, 1'b0, 32'd0, 32'd0);
        tick();
        idle_in();
        bus.csr_ready = 1'b1;
        #1;
        n_checks++; if (bus.csr_we !== 1'b1 || bus.trap_valid !== 1'b0) begin n_fail++; $display("FAIL trap_a_commit: got csr_we %0b trap_valid %0b want 1/0", bus.csr_we, bus.trap_valid); end
        tick();
        set_in(1'b1, 5'd9, 32'h9, 1'b0, 12'd0, 32'd0, 1'b0, 32'd0, 32'd0);
        #1;
        n_checks++; if (bus.trap_valid !== 1'b1 || bus.trap_mcause !== 32'h2 || bus.trap_pc !== 32'h100) begin n_fail++; $display("FAIL trap_pulse: got %0b %0h %0h want 1/2/100", bus.trap_valid, bus.trap_mcause, bus.trap_pc); end
        n_checks++; if (bus.rd_we !== 1'b0 || bus.csr_we !== 1'b0 || bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL trap_side: got rd_we %0b csr_we %0b in_ready %0b want 0/0/0", bus.rd_we, bus.csr_we, bus.in_ready); end
        tick();
        idle_in();
        #1;
        n_checks++; if (bus.count !== 3'd0 || bus.instret !== 64'd10) begin n_fail++; $display("FAIL trap_discard: got count %0d instret %0d want 0/10", bus.count, bus.instret); end
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (bus.rd_we !== 1'b0 || bus.trap_valid !== 1'b0) begin n_fail++; $display("FAIL trap_quiet[%0d]: got rd_we %0b trap_valid %0b want 0/0", i, bus.rd_we, bus.trap_valid); end
            tick();
            #1;
        end
    endtask

    task automatic test_flush();
        bus.csr_ready = 1'b1;
        set_in(1'b1, 5'd6, 32'h66, 1'b0, 12'd0, 32'd0, 1'b0, 32'd0, 32'd0);
        tick();
        bus.flush = 1'b1;
        #1;
        n_checks++; if (bus.rd_we !== 1'b0 || bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_gate: got rd_we %0b in_ready %0b want 0/0", bus.rd_we, bus.in_ready); end
        tick();
        bus.flush = 1'b0;
        idle_in();
        #1;
        n_checks++; if (bus.count !== 3'd0 || bus.instret !== 64'd10) begin n_fail++; $display("FAIL flush_clear: got count %0d instret %0d want 0/10", bus.count, bus.instret); end
        set_in(1'b1, 5'd0, 32'd0, 1'b0, 12'd0, 32'd0, 1'b1, 32'h7, 32'h200);
        tick();
        idle_in();
        bus.flush = 1'b1;
        #1;
        n_checks++; if (bus.trap_valid !== 1'b0) begin n_fail++; $display("FAIL flush_vs_trap: got %0b want 0", bus.trap_valid); end
        tick();
        bus.flush = 1'b0;
        #1;
        n_checks++; if (bus.count !== 3'd0) begin n_fail++; $display("FAIL flush_trap_clear: got %0d want 0", bus.count); end
    endtask

    task automatic test_reset_mid();
        bus.csr_ready = 1'b0;
        set_in(1'b1, 5'd0, 32'd0, 1'b1, 12'h341, 32'h3, 1'b0, 32'd0, 32'd0);
        tick();
        set_in(1'b1, 5'd1, 32'h1, 1'b0, 12'd0, 32'd0, 1'b0, 32'd0, 32'd0);
        tick();
        tick();
        idle_in();
        #1;
        n_checks++; if (bus.count !== 3'd3 || bus.csr_we !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre: got count %0d csr_we %0b want 3/1", bus.count, bus.csr_we); end
        rst = 1'b1;
        #1;
        n_checks++; if (bus.csr_we !== 1'b0 || bus.rd_we !== 1'b0 || bus.trap_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_strobes: got %0b%0b%0b want 000", bus.csr_we, bus.rd_we, bus.trap_valid); end
        n_checks++; if (bus.count !== 3'd0 || bus.instret !== 64'd0 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_state: got count %0d instret %0d in_ready %0b want 0/0/1", bus.count, bus.instret, bus.in_ready); end
        tick();
        rst = 1'b0;
        tick();
        #1;
        n_checks++; if (bus.count !== 3'd0 || bus.csr_we !== 1'b0) begin n_fail++; $display("FAIL rstmid_after: got count %0d csr_we %0b want 0/0", bus.count, bus.csr_we); end
    endtask

    task automatic test_random();
        logic [63:0] m_instret;
        ent_t h, e;
        logic e_commit, e_trap, e_ready, e_rd_we, e_csr_we;
        m_instret = 64'd0;
        mdl_q.delete();
        for (int cyc = 0; cyc < 600; cyc++) begin
            e.rd = 5'($urandom_range(0, 31));
            e.wd = $urandom;
            e.cwe = ($urandom_range(0, 3) == 0);
            e.ca = 12'($urandom);
            e.cd = $urandom;
            e.trap = ($urandom_range(0, 9) == 0);
            e.mc = $urandom;
            e.pc = $urandom;
            set_in(($urandom_range(0, 3) != 0), e.rd, e.wd, e.cwe, e.ca, e.cd, e.trap, e.mc, e.pc);
            bus.csr_ready = $urandom_range(0, 1);
            bus.flush = ($urandom_range(0, 19) == 0);
            #1;
            e_commit = 1'b0; e_trap = 1'b0; e_rd_we = 1'b0; e_csr_we = 1'b0;
            if (mdl_q.size() != 0) begin
                h = mdl_q[0];
                e_csr_we = h.cwe && !h.trap && !bus.flush;
                e_commit = !bus.flush && (h.trap || !h.cwe || bus.csr_ready);
                e_trap = e_commit && h.trap;
                e_rd_we = e_commit && !h.trap && (h.rd != 5'd0);
            end
            e_ready = !bus.flush && !e_trap && (mdl_q.size() < DEPTH || e_commit);
            n_checks++; if (bus.count !== 3'(mdl_q.size())) begin n_fail++; $display("FAIL rnd_count@%0d: got %0d want %0d", cyc, bus.count, mdl_q.size()); end
            n_checks++; if (bus.in_ready !== e_ready) begin n_fail++; $display("FAIL rnd_in_ready@%0d: got %0b want %0b", cyc, bus.in_ready, e_ready); end
            n_checks++; if (bus.rd_we !== e_rd_we || bus.csr_we !== e_csr_we || bus.trap_valid !== e_trap) begin n_fail++; $display("FAIL rnd_strobes@%0d: got %0b%0b%0b want %0b%0b%0b", cyc, bus.rd_we, bus.csr_we, bus.trap_valid, e_rd_we, e_csr_we, e_trap); end
            if (e_rd_we) begin
                n_checks++; if (bus.rd_addr !== h.rd || bus.rd_wdata !== h.wd) begin n_fail++; $display("FAIL rnd_rd_data@%0d: got %0d/%0h want %0d/%0h", cyc, bus.rd_addr, bus.rd_wdata, h.rd, h.wd); end
            end
            if (e_csr_we) begin
                n_checks++; if (bus.csr_addr !== h.ca || bus.csr_wdata !== h.cd) begin n_fail++; $display("FAIL rnd_csr_data@%0d: got %0h/%0h want %0h/%0h", cyc, bus.csr_addr, bus.csr_wdata, h.ca, h.cd); end
            end
            if (e_trap) begin
                n_checks++; if (bus.trap_mcause !== h.mc || bus.trap_pc !== h.pc) begin n_fail++; $display("FAIL rnd_trap_data@%0d: got %0h/%0h want %0h/%0h", cyc, bus.trap_mcause, bus.trap_pc, h.mc, h.pc); end
            end
            n_checks++; if (bus.instret !== m_instret) begin n_fail++; $display("FAIL rnd_instret@%0d: got %0d want %0d", cyc, bus.instret, m_instret); end
            @(posedge clk);
            if (e_commit && !e_trap) m_instret = m_instret + 64'd1;
            if (bus.flush || e_trap) begin
                mdl_q.delete();
            end else begin
                if (e_commit) void'(mdl_q.pop_front());
                if (bus.in_valid && e_ready) mdl_q.push_back(e);
            end
            @(negedge clk);
        end
        idle_in();
        bus.flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_x0();
        test_csr_stall();
        test_full();
        test_trap();
        test_flush();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
